// File: rtl/arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: FSM encoding and
// small helpers for weight handling and one-hot decoding.
package arb_pkg;

   localparam int MAX_N = 64;

   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_HOLD = 1'b1;

   // A programmed weight of zero still grants once.
   function automatic int unsigned eff_weight(input int unsigned w);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic int unsigned onehot_to_bin(input logic [MAX_N-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating picker: first requester strictly after the most-recent grantee,
// found by rotate, lowest-set-bit select, rotate back.
module rr_pick
   import arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] req,
   input  logic [WIDTH-1:0] mrg,
   output logic [WIDTH-1:0] grt
);

   localparam int IDX_W = $clog2(WIDTH);

   logic [IDX_W-1:0]   shift;
   logic [2*WIDTH-1:0] req_dbl;
   logic [2*WIDTH-1:0] pick_dbl;
   logic [WIDTH-1:0]   rot_req;
   logic [WIDTH-1:0]   rot_pick;
   int unsigned        mrg_idx;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      mrg_idx  = onehot_to_bin(MAX_N'(mrg));
      shift    = (mrg_idx == WIDTH - 1) ? '0 : IDX_W'(mrg_idx + 1);
      req_dbl  = {req, req} >> shift;
      rot_req  = req_dbl[WIDTH-1:0];
      rot_pick = rot_req & (~rot_req + WIDTH'(1));
      pick_dbl = {rot_pick, rot_pick} << shift;
      grt      = pick_dbl[2*WIDTH-1:WIDTH];
   end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with acknowledge handshake and fixed-priority
// mode; a winner may keep the grant for up to its weight of accepted grants.
module wrr_arbiter
   import arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int WGT_W = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           req,
   input  logic [WIDTH*WGT_W-1:0]     weight,
   input  logic                       mode,
   input  logic                       ack,
   output logic [WIDTH-1:0]           grt,
   output logic [$clog2(WIDTH)-1:0]   grt_id,
   output logic                       grt_valid,
   output logic                       locked
);

   localparam int ID_W = $clog2(WIDTH);

   logic [WIDTH-1:0] mrg_q,   mrg_d;
   logic [WIDTH-1:0] owner_q, owner_d;
   logic [WGT_W-1:0] cnt_q,   cnt_d;
   logic             state_q, state_d;

   logic [WIDTH-1:0] rr_grt;
   logic [WIDTH-1:0] fp_grt;
   logic [WGT_W-1:0] win_wgt;
   int unsigned      win_eff;
   logic             hold;
   logic             accept;

   rr_pick #(.WIDTH(WIDTH)) u_rr_pick (
      .req (req),
      .mrg (mrg_q),
      .grt (rr_grt)
   );

   assign fp_grt = req & (~req + WIDTH'(1));
   assign hold   = (state_q == STATE_HOLD) & (|(req & owner_q)) & ~mode;

   always_comb begin
      if (hold)      grt = owner_q;
      else if (mode) grt = fp_grt;
      else           grt = rr_grt;
   end

   assign grt_valid = |grt;
   assign grt_id    = ID_W'(onehot_to_bin(MAX_N'(grt)));
   assign locked    = hold;
   assign accept    = ack & grt_valid;

   always_comb begin
      win_wgt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (grt[i]) win_wgt = weight[i*WGT_W +: WGT_W];
      end
      win_eff = eff_weight(32'(win_wgt));
   end

   always_comb begin
      mrg_d   = mrg_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (mode) begin
         state_d = STATE_IDLE;
         owner_d = '0;
      end else if (accept) begin
         if (hold) begin
            cnt_d = cnt_q - WGT_W'(1);
            if (cnt_q == WGT_W'(1)) begin
               state_d = STATE_IDLE;
               owner_d = '0;
            end
         end else begin
            // Not holding (idle, or the owner dropped its request): fresh win.
            mrg_d = grt;
            if (win_eff == 1) begin
               state_d = STATE_IDLE;
               owner_d = '0;
            end else begin
               state_d = STATE_HOLD;
               owner_d = grt;
               cnt_d   = WGT_W'(win_eff - 1);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mrg_q   <= WIDTH'(1) << (WIDTH - 1);
         owner_q <= '0;
         cnt_q   <= '0;
         state_q <= STATE_IDLE;
      end else begin
         mrg_q   <= mrg_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

endmodule
